// File: rtl/scanline_pkg.sv
// Shared types and constants for the scanline scheduling controller.
`timescale 1ns/1ps
package scanline_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t SL_OFF = 2'd0;
    localparam mode_t SL_25  = 2'd1;
    localparam mode_t SL_50  = 2'd2;
    localparam mode_t SL_75  = 2'd3;

    localparam int LINE_CNT_W_DEF  = 11;
    localparam int HIRES_LINES_DEF = 400;

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

endpackage

// File: rtl/scanline_sched_if.sv
// Host-side mode request handshake (valid/ready) for scanline_sched.
`timescale 1ns/1ps
interface scanline_sched_if;
    import scanline_pkg::*;

    logic  cfg_valid;
    mode_t cfg_mode;
    logic  cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        output cfg_ready
    );

endinterface

// File: rtl/sync_edge_det.sv
// One-bit edge detector: compares the input against its registered history.
`timescale 1ns/1ps
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic old_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old_reg <= 1'b0;
        end else begin
            old_reg <= d;
        end
    end

    assign rise = ~old_reg & d;
    assign fall = old_reg & ~d;

endmodule

// File: rtl/scanline_sched.sv
// Frame-synchronous scanline mode scheduler: requests commit only on vsync fall.
// Optional macro SCANLINE_SCHED_FIELD_EN: alternating-field suppression for interlaced sources.
`timescale 1ns/1ps
module scanline_sched
    import scanline_pkg::*;
#(
    parameter int HIRES_LINES = HIRES_LINES_DEF,
    parameter int LINE_CNT_W  = LINE_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    scanline_sched_if.slave       cfg,
    input  logic                  hs_in,
    input  logic                  vs_in,
    input  logic                  de_in,
    output logic [1:0]            scanlines,
    output logic                  applied,
    output logic                  pending,
    output logic                  hires,
    output logic [LINE_CNT_W-1:0] lines_per_frame,
    output logic                  field
);

    localparam logic [LINE_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [LINE_CNT_W-1:0] HIRES_THR = LINE_CNT_W'(HIRES_LINES);

    logic vs_fall;
    logic de_rise;
    logic unused_vs_rise;
    logic unused_de_fall;
    logic unused_hs;

    // hsync is carried on the port only so this block matches the video bus.
    assign unused_hs = hs_in;

    sync_edge_det u_vs_edge (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (vs_in),
        .rise  (unused_vs_rise),
        .fall  (vs_fall)
    );

    sync_edge_det u_de_edge (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (de_in),
        .rise  (de_rise),
        .fall  (unused_de_fall)
    );

    state_t                  state_reg, state_next;
    mode_t                   req_mode_reg, req_mode_next;
    mode_t                   scan_reg, scan_next;
    logic                    applied_reg, applied_next;
    logic                    hires_reg, hires_next;
    logic                    field_reg, field_next;
    logic [LINE_CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic [LINE_CNT_W-1:0]   lpf_reg, lpf_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            req_mode_reg <= SL_OFF;
            scan_reg     <= SL_OFF;
            applied_reg  <= 1'b0;
            hires_reg    <= 1'b0;
            field_reg    <= 1'b0;
            cnt_reg      <= '0;
            lpf_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            req_mode_reg <= req_mode_next;
            scan_reg     <= scan_next;
            applied_reg  <= applied_next;
            hires_reg    <= hires_next;
            field_reg    <= field_next;
            cnt_reg      <= cnt_next;
            lpf_reg      <= lpf_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        req_mode_next = req_mode_reg;
        scan_next     = scan_reg;
        applied_next  = 1'b0;
        hires_next    = hires_reg;
        field_next    = field_reg;
        lpf_next      = lpf_reg;
        cnt_inc       = cnt_reg;

        if (de_rise && (cnt_reg != CNT_MAX)) begin
            cnt_inc = cnt_reg + 1'b1;
        end
        cnt_next = cnt_inc;

        // The frame boundary reports the count including a coincident de rise,
        // and re-evaluates the output so hi-res exit restores the last mode.
        if (vs_fall) begin
            cnt_next   = '0;
            lpf_next   = cnt_inc;
            hires_next = (cnt_inc > HIRES_THR);
`ifdef SCANLINE_SCHED_FIELD_EN
            field_next = ~field_reg;
`endif
            scan_next  = (hires_next || field_next) ? SL_OFF : req_mode_reg;
        end

        // A request accepted on the vsync-fall cycle is only latched here;
        // it waits in PEND for the following frame boundary.
        case (state_reg)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    req_mode_next = cfg.cfg_mode;
                    state_next    = PEND;
                end
            end
            PEND: begin
                if (vs_fall) begin
                    applied_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cfg.cfg_ready    = (state_reg == IDLE);
    assign pending          = (state_reg == PEND);
    assign scanlines        = scan_reg;
    assign applied          = applied_reg;
    assign hires            = hires_reg;
    assign lines_per_frame  = lpf_reg;
    assign field            = field_reg;

endmodule
